// File: rtl/power_control.sv
// Power sequencing for the hood: debounces the power button, runs the
// OFF / ON_HOLD / ON / OFF_HOLD state machine, and auto-powers-off after
// an idle period in standby. All outputs come straight from flops.
module power_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ONE_SECOND      = 100000000,
    parameter int unsigned LONG_PRESS_S    = 3,
    parameter int unsigned IDLE_OFF_S      = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_btn,
    input  logic [2:0] mode,
    output logic       power_state,
    output logic       on_pulse,
    output logic       off_pulse,
    output logic [7:0] idle_secs_left
);

    localparam int unsigned HOLD_CYCLES = LONG_PRESS_S * ONE_SECOND;
    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PRE_W  = (ONE_SECOND > 1) ? $clog2(ONE_SECOND) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(ONE_SECOND - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]        IDLE_RELOAD = 8'(IDLE_OFF_S);

    typedef enum logic [1:0] {
        StOff,
        StOnHold,
        StOn,
        StOffHold
    } state_e;

    state_e state_q, state_d;

    logic              sync_meta_q, sync_q;
    logic              btn_stable_q, btn_stable_d;
    logic              btn_stable_prev_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [7:0]        secs_q, secs_d;
    logic              power_state_q, power_state_d;
    logic              on_pulse_q, on_pulse_d;
    logic              off_pulse_q, off_pulse_d;

    logic pressed;
    logic idle_reload;
    logic idle_expire;

    // Two-flop synchronizer for the raw button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= power_btn;
            sync_q      <= sync_meta_q;
        end
    end

    // Debounce: the stable level follows sync only after an unbroken run of disagreement.
    always_comb begin
        btn_stable_d = btn_stable_q;
        deb_cnt_d    = '0;
        if (sync_q != btn_stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                btn_stable_d = sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign pressed = btn_stable_q & ~btn_stable_prev_q;

    // Next state, hold counter, idle timer and output strobes.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = '0;
        presc_d     = presc_q;
        secs_d      = secs_q;
        idle_expire = 1'b0;

        // A held button keeps the idle timer reloaded, so idle expiry can never
        // coincide with a long press; a mode change on the wrap cycle wins too.
        idle_reload = (mode != 3'b000) | btn_stable_q | (state_q != StOn);

        if (idle_reload) begin
            presc_d = '0;
            secs_d  = IDLE_RELOAD;
        end else if (presc_q == PRE_LAST) begin
            presc_d = '0;
            if (secs_q != 8'd0) begin
                secs_d = secs_q - 8'd1;
            end
            idle_expire = (secs_q == 8'd1);
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end

        unique case (state_q)
            StOff: begin
                if (pressed) begin
                    state_d = StOnHold;
                end
            end
            // Turn-on press must be released before it can count as a long press.
            StOnHold: begin
                if (!btn_stable_q) begin
                    state_d = StOn;
                end
            end
            StOn: begin
                if (btn_stable_q) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = StOffHold;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end else if (idle_expire) begin
                    state_d = StOff;
                end
            end
            StOffHold: begin
                if (!btn_stable_q) begin
                    state_d = StOff;
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase

        power_state_d = (state_d == StOnHold) || (state_d == StOn);
        on_pulse_d    = power_state_d & ~power_state_q;
        off_pulse_d   = ~power_state_d & power_state_q;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= StOff;
            btn_stable_q      <= 1'b0;
            btn_stable_prev_q <= 1'b0;
            deb_cnt_q         <= '0;
            hold_cnt_q        <= '0;
            presc_q           <= '0;
            secs_q            <= IDLE_RELOAD;
            power_state_q     <= 1'b0;
            on_pulse_q        <= 1'b0;
            off_pulse_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            btn_stable_q      <= btn_stable_d;
            btn_stable_prev_q <= btn_stable_q;
            deb_cnt_q         <= deb_cnt_d;
            hold_cnt_q        <= hold_cnt_d;
            presc_q           <= presc_d;
            secs_q            <= secs_d;
            power_state_q     <= power_state_d;
            on_pulse_q        <= on_pulse_d;
            off_pulse_q       <= off_pulse_d;
        end
    end

    assign power_state    = power_state_q;
    assign on_pulse       = on_pulse_q;
    assign off_pulse      = off_pulse_q;
    assign idle_secs_left = secs_q;

endmodule

// File: tb/tb_power_control.sv
// Testbench for power_control: directed scenarios with exact cycle timing, then
// random press lengths checked against a press-length rule model.
module tb_power_control;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SEC  = 10;
    localparam int unsigned LONG = 3;
    localparam int unsigned IDLE = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       power_btn = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       power_state;
    logic       on_pulse;
    logic       off_pulse;
    logic [7:0] idle_secs_left;

    int checks = 0;
    int errors = 0;
    int on_seen = 0;
    int off_seen = 0;

    power_control #(
        .DEBOUNCE_CYCLES(DEB),
        .ONE_SECOND     (SEC),
        .LONG_PRESS_S   (LONG),
        .IDLE_OFF_S     (IDLE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .power_btn     (power_btn),
        .mode          (mode),
        .power_state   (power_state),
        .on_pulse      (on_pulse),
        .off_pulse     (off_pulse),
        .idle_secs_left(idle_secs_left)
    );

    always #5 clk = ~clk;

    // Count strobe cycles away from the active edge.
    always @(negedge clk) begin
        if (on_pulse === 1'b1) on_seen++;
        if (off_pulse === 1'b1) off_seen++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // From OFF with the button released: 8-cycle press, hood on 2+DEB+1 cycles later.
    task automatic turn_on(input string name);
        power_btn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check($sformatf("%s_ps_k%0d", name, k), power_state, (k >= 7) ? 1 : 0);
            check($sformatf("%s_onp_k%0d", name, k), on_pulse, (k == 7) ? 1 : 0);
            check($sformatf("%s_secs_k%0d", name, k), idle_secs_left, IDLE);
        end
        power_btn = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        check($sformatf("%s_ps_after", name), power_state, 1);
        check($sformatf("%s_secs_after", name), idle_secs_left, IDLE);
    endtask

    initial begin
        int   len;
        bit   model_on;
        int   exp_on;
        int   exp_off;
        int   on0;
        int   off0;
        logic [2:0] modes [4];
        modes[0] = 3'b001;
        modes[1] = 3'b010;
        modes[2] = 3'b100;
        modes[3] = 3'b111;

        // Reset values.
        for (int k = 0; k < 3; k++) cyc();
        check("rst_ps", power_state, 0);
        check("rst_onp", on_pulse, 0);
        check("rst_offp", off_pulse, 0);
        check("rst_secs", idle_secs_left, IDLE);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        check("rel_ps", power_state, 0);
        check("rel_secs", idle_secs_left, IDLE);

        // 1: short press turns on.
        mode = 3'b001;
        turn_on("t1");

        // 2: 3-cycle glitch is rejected.
        power_btn = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            check($sformatf("t2_ps_k%0d", k), power_state, 1);
            check($sformatf("t2_onp_k%0d", k), on_pulse, 0);
            check($sformatf("t2_offp_k%0d", k), off_pulse, 0);
            if (k == 3) power_btn = 1'b0;
        end

        // 3: long press; stable rises at edge 6, power falls 30 cycles later.
        power_btn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            check($sformatf("t3_ps_k%0d", k), power_state, (k < 36) ? 1 : 0);
            check($sformatf("t3_offp_k%0d", k), off_pulse, (k == 36) ? 1 : 0);
            check($sformatf("t3_onp_k%0d", k), on_pulse, 0);
        end
        power_btn = 1'b0;
        for (int k = 0; k < 12; k++) cyc();
        check("t3_ps_released", power_state, 0);
        turn_on("t3_reon");

        // 4: standby idle countdown from the last reload cycle.
        mode = 3'b000;
        for (int k = 1; k <= 55; k++) begin
            cyc();
            check($sformatf("t4_secs_k%0d", k), idle_secs_left,
                  (k < 50) ? (IDLE - k / SEC) : ((k == 50) ? 0 : IDLE));
            check($sformatf("t4_ps_k%0d", k), power_state, (k < 50) ? 1 : 0);
            check($sformatf("t4_offp_k%0d", k), off_pulse, (k == 50) ? 1 : 0);
        end

        // 6: reset while in ON_HOLD with the button held.
        mode = 3'b001;
        power_btn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check($sformatf("t6_pre_ps_k%0d", k), power_state, (k >= 7) ? 1 : 0);
        end
        reset = 1'b0;
        #1;
        check("t6_rst_ps", power_state, 0);
        check("t6_rst_secs", idle_secs_left, IDLE);
        check("t6_rst_onp", on_pulse, 0);
        cyc();
        cyc();
        check("t6_in_rst_ps", power_state, 0);
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check($sformatf("t6_ps_k%0d", k), power_state, (k >= 7) ? 1 : 0);
            check($sformatf("t6_onp_k%0d", k), on_pulse, (k == 7) ? 1 : 0);
        end
        power_btn = 1'b0;
        for (int k = 0; k < 12; k++) cyc();
        check("t6_ps_after", power_state, 1);

        // 5: mode change on the final wrap cycle reloads the timer.
        mode = 3'b000;
        for (int k = 1; k <= 49; k++) begin
            cyc();
            check($sformatf("t5_secs_k%0d", k), idle_secs_left, IDLE - k / SEC);
        end
        mode = 3'b010;
        cyc();
        check("t5_wrap_secs", idle_secs_left, IDLE);
        check("t5_wrap_ps", power_state, 1);
        check("t5_wrap_offp", off_pulse, 0);
        for (int k = 0; k < 10; k++) cyc();
        check("t5_hold_secs", idle_secs_left, IDLE);
        check("t5_hold_ps", power_state, 1);

        // Random press lengths: >= DEB cycles is a press; from ON, a press whose
        // stable level lasts LONG*SEC cycles or more powers off.
        model_on = 1'b1;
        for (int it = 0; it < 30; it++) begin
            mode = modes[$urandom_range(0, 3)];
            len  = $urandom_range(1, 45);
            on0  = on_seen;
            off0 = off_seen;
            exp_on  = 0;
            exp_off = 0;
            if (len >= DEB) begin
                if (!model_on) begin
                    model_on = 1'b1;
                    exp_on   = 1;
                end else if (len >= LONG * SEC) begin
                    model_on = 1'b0;
                    exp_off  = 1;
                end
            end
            power_btn = 1'b1;
            for (int k = 0; k < len; k++) cyc();
            power_btn = 1'b0;
            for (int k = 0; k < 14; k++) cyc();
            check($sformatf("rnd%0d_L%0d_ps", it, len), power_state, model_on);
            check($sformatf("rnd%0d_L%0d_on", it, len), on_seen - on0, exp_on);
            check($sformatf("rnd%0d_L%0d_off", it, len), off_seen - off0, exp_off);
            check($sformatf("rnd%0d_L%0d_secs", it, len), idle_secs_left, IDLE);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
